// File: rtl/attack_round_fsm_if.sv
// Attack-round controller bus: map load, coordinate entry and result/status signals.
// The master drives the round inputs; the slave (the controller) drives the status side.
interface attack_round_fsm_if #(
  parameter int COLUNE_SIZE   = 7,
  parameter int TOTAL_COLUNES = 5,
  parameter int COORD_WIDTH   = 3,
  parameter int MAX_ATTACKS   = 15
);
  localparam int DATA_WIDTH = COLUNE_SIZE * TOTAL_COLUNES;
  localparam int CW         = $clog2(DATA_WIDTH + 1);
  localparam int AW         = $clog2(MAX_ATTACKS + 1);

  logic                   start;
  logic [DATA_WIDTH-1:0]  selected_map;
  logic [COORD_WIDTH-1:0] x_coord;
  logic [COORD_WIDTH-1:0] y_coord;
  logic                   confirm_attack;
  logic [DATA_WIDTH-1:0]  matriz_data;
  logic [DATA_WIDTH-1:0]  hit_map;
  logic                   result_valid;
  logic [1:0]             result_code;
  logic [CW-1:0]          hits_count;
  logic [AW-1:0]          attacks_left;
  logic                   round_over;
  logic                   player_won;

  modport master (
    output start, selected_map, x_coord, y_coord, confirm_attack,
    input  matriz_data, hit_map, result_valid, result_code,
           hits_count, attacks_left, round_over, player_won
  );

  modport slave (
    input  start, selected_map, x_coord, y_coord, confirm_attack,
    output matriz_data, hit_map, result_valid, result_code,
           hits_count, attacks_left, round_over, player_won
  );
endinterface

// File: rtl/attack_round_fsm.sv
// Battleship attack-round controller: result 2 cycles after a confirm edge is sampled.
// No backpressure; edges arriving outside ARMED (EVAL, DONE, IDLE) are dropped, not queued.
module attack_round_fsm #(
  parameter int COLUNE_SIZE   = 7,
  parameter int TOTAL_COLUNES = 5,
  parameter int COORD_WIDTH   = 3,
  parameter int MAX_ATTACKS   = 15
) (
  input  logic               clk,
  input  logic               reset,
  attack_round_fsm_if.slave  bus
);
  localparam int DATA_WIDTH = COLUNE_SIZE * TOTAL_COLUNES;
  localparam int CW         = $clog2(DATA_WIDTH + 1);
  localparam int AW         = $clog2(MAX_ATTACKS + 1);
  localparam int IW         = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, ARMED, EVAL, DONE} state_t;

  state_t                 state;
  logic [DATA_WIDTH-1:0]  ship_map;
  logic [DATA_WIDTH-1:0]  attacked;
  logic [CW-1:0]          total_ships;
  logic [CW-1:0]          hits_count;
  logic [AW-1:0]          attacks_left;
  logic                   conf_prev;
  logic [COORD_WIDTH-1:0] x_l;
  logic [COORD_WIDTH-1:0] y_l;
  logic                   result_valid;
  logic [1:0]             result_code;
  logic                   round_over;
  logic                   player_won;

  logic                   conf_edge;
  logic                   coord_bad;
  logic [IW-1:0]          idx;
  logic                   is_ship;
  logic                   already_hit;
  logic [CW-1:0]          hits_next;
  logic [AW-1:0]          left_next;
  logic [CW-1:0]          map_pop;

  // idx is only meaningful when coord_bad is low; the out-of-range value is never used.
  always_comb begin
    conf_edge   = bus.confirm_attack & ~conf_prev;
    coord_bad   = (int'(x_l) >= TOTAL_COLUNES) || (int'(y_l) >= COLUNE_SIZE);
    idx         = IW'(int'(x_l) * COLUNE_SIZE + int'(y_l));
    is_ship     = ship_map[idx];
    already_hit = attacked[idx];
    hits_next   = hits_count + CW'(is_ship);
    left_next   = attacks_left - AW'(1);
    map_pop     = CW'($countones(bus.selected_map));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      ship_map     <= '0;
      attacked     <= '0;
      total_ships  <= '0;
      hits_count   <= '0;
      attacks_left <= '0;
      conf_prev    <= 1'b0;
      x_l          <= '0;
      y_l          <= '0;
      result_valid <= 1'b0;
      result_code  <= 2'b00;
      round_over   <= 1'b0;
      player_won   <= 1'b0;
    end else begin
      conf_prev    <= bus.confirm_attack;
      result_valid <= 1'b0;
      if (bus.start) begin
        ship_map     <= bus.selected_map;
        attacked     <= '0;
        hits_count   <= '0;
        attacks_left <= AW'(MAX_ATTACKS);
        total_ships  <= map_pop;
        result_code  <= 2'b00;
        if (map_pop == '0) begin
          state      <= DONE;
          round_over <= 1'b1;
          player_won <= 1'b1;
        end else begin
          state      <= ARMED;
          round_over <= 1'b0;
          player_won <= 1'b0;
        end
      end else begin
        case (state)
          ARMED: begin
            if (conf_edge) begin
              x_l   <= bus.x_coord;
              y_l   <= bus.y_coord;
              state <= EVAL;
            end
          end
          EVAL: begin
            result_valid <= 1'b1;
            state        <= ARMED;
            if (coord_bad) begin
              result_code <= 2'b11;
            end else if (already_hit) begin
              result_code <= 2'b10;
            end else begin
              attacked[idx] <= 1'b1;
              attacks_left  <= left_next;
              hits_count    <= hits_next;
              result_code   <= is_ship ? 2'b01 : 2'b00;
              // A winning final shot outranks running out of attacks.
              if (hits_next == total_ships) begin
                state      <= DONE;
                round_over <= 1'b1;
                player_won <= 1'b1;
              end else if (left_next == '0) begin
                state      <= DONE;
                round_over <= 1'b1;
                player_won <= 1'b0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.matriz_data  = attacked;
  assign bus.hit_map      = attacked & ship_map;
  assign bus.result_valid = result_valid;
  assign bus.result_code  = result_code;
  assign bus.hits_count   = hits_count;
  assign bus.attacks_left = attacks_left;
  assign bus.round_over   = round_over;
  assign bus.player_won   = player_won;
endmodule
